// File: rtl/tick_timer.sv
// tick_timer: tick-driven countdown timer with a valid/ready load, one-shot or
// periodic reload, and sticky expired/overrun flags.
`default_nettype none

module tick_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] load_period_i,
  input  logic             load_periodic_i,
  input  logic             stop_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] remaining_o,
  output logic             expired_o,
  output logic             overrun_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             periodic_q, periodic_d;
  logic             expired_q, expired_d;
  logic             overrun_q, overrun_d;
  logic             w_accept;
  logic             w_expire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      remaining_q <= '0;
      periodic_q  <= 1'b0;
      expired_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      remaining_q <= remaining_d;
      periodic_q  <= periodic_d;
      expired_q   <= expired_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    remaining_d = remaining_q;
    periodic_d  = periodic_q;
    w_accept    = 1'b0;
    w_expire    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_valid_i) begin
          w_accept   = 1'b1;
          period_d   = load_period_i;
          periodic_d = load_periodic_i;
          // A zero period expires immediately without ever entering RUN.
          if (load_period_i == C_ZERO) begin
            w_expire = 1'b1;
          end else begin
            remaining_d = load_period_i;
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (stop_i) begin
          remaining_d = '0;
          state_d     = S_IDLE;
        end else if (tick_i) begin
          if (remaining_q == C_ONE) begin
            w_expire = 1'b1;
            if (periodic_q) begin
              remaining_d = period_q;
            end else begin
              remaining_d = '0;
              state_d     = S_IDLE;
            end
          end else begin
            remaining_d = remaining_q - C_ONE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // Expiry beats ack for the expired flag; ack always clears overrun.
  always_comb begin
    expired_d = expired_q;
    overrun_d = overrun_q;
    if (w_expire) begin
      expired_d = 1'b1;
      if (ack_i) begin
        overrun_d = 1'b0;
      end else if (expired_q) begin
        overrun_d = 1'b1;
      end
    end else if (ack_i) begin
      expired_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    busy_o       = (state_q == S_RUN);
    load_ready_o = (state_q == S_IDLE);
    remaining_o  = remaining_q;
    expired_o    = expired_q;
    overrun_o    = overrun_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_tick_timer.sv
// tb_tick_timer: directed vector table, async reset sequence, then random
// stimulus checked against a behavioural model.
`default_nettype none

module tb_tick_timer;

  localparam int WIDTH = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             tick_i;
  logic             load_valid_i;
  logic             load_ready_o;
  logic [WIDTH-1:0] load_period_i;
  logic             load_periodic_i;
  logic             stop_i;
  logic             ack_i;
  logic             busy_o;
  logic [WIDTH-1:0] remaining_o;
  logic             expired_o;
  logic             overrun_o;

  int total = 0;
  int bad   = 0;

  tick_timer #(.WIDTH(WIDTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .tick_i         (tick_i),
    .load_valid_i   (load_valid_i),
    .load_ready_o   (load_ready_o),
    .load_period_i  (load_period_i),
    .load_periodic_i(load_periodic_i),
    .stop_i         (stop_i),
    .ack_i          (ack_i),
    .busy_o         (busy_o),
    .remaining_o    (remaining_o),
    .expired_o      (expired_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit tick;
    bit lv;
    int lp;
    bit lper;
    bit stop;
    bit ack;
    bit e_busy;
    int e_rem;
    bit e_exp;
    bit e_ov;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: plain integers, updated once per clock edge.
  bit m_run, m_periodic, m_exp, m_ov;
  int m_rem, m_per;

  function automatic vec_t mk(bit t, bit lv, int lp, bit lper, bit s, bit a,
                              bit eb, int er, bit ee, bit eo);
    vec_t v;
    v.tick = t; v.lv = lv; v.lp = lp; v.lper = lper; v.stop = s; v.ack = a;
    v.e_busy = eb; v.e_rem = er; v.e_exp = ee; v.e_ov = eo;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit t, bit lv, int lp, bit lper, bit s, bit a);
    tick_i = t; load_valid_i = lv; load_period_i = lp[WIDTH-1:0];
    load_periodic_i = lper; stop_i = s; ack_i = a;
  endtask

  task automatic check_all(string tag, bit eb, int er, bit ee, bit eo);
    chk({tag, ".busy"}, {31'd0, busy_o}, {31'd0, eb});
    chk({tag, ".ready"}, {31'd0, load_ready_o}, {31'd0, ~eb});
    chk({tag, ".remaining"}, {16'd0, remaining_o}, er);
    chk({tag, ".expired"}, {31'd0, expired_o}, {31'd0, ee});
    chk({tag, ".overrun"}, {31'd0, overrun_o}, {31'd0, eo});
  endtask

  task automatic model_reset();
    m_run = 0; m_periodic = 0; m_exp = 0; m_ov = 0; m_rem = 0; m_per = 0;
  endtask

  task automatic model_step(bit t, bit lv, int lp, bit lper, bit s, bit a);
    bit fire = 0;
    if (!m_run) begin
      if (lv) begin
        m_per = lp; m_periodic = lper;
        if (lp == 0) fire = 1;
        else begin m_rem = lp; m_run = 1; end
      end
    end else if (s) begin
      m_run = 0; m_rem = 0;
    end else if (t) begin
      if (m_rem == 1) begin
        fire = 1;
        if (m_periodic) m_rem = m_per;
        else begin m_rem = 0; m_run = 0; end
      end else begin
        m_rem = m_rem - 1;
      end
    end
    if (fire) begin
      if (a) m_ov = 0;
      else if (m_exp) m_ov = 1;
      m_exp = 1;
    end else if (a) begin
      m_exp = 0; m_ov = 0;
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk_i);
    #1;
    check_all("reset", 0, 0, 0, 0);
    rst_ni = 1'b1;

    // one-shot period 3
    vecs.push_back(mk(0,1,3,0,0,0, 1,3,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,3,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,2,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0));
    // periodic period 2, overrun on 2nd expiry
    vecs.push_back(mk(0,1,2,1,0,0, 1,2,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,2,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,2,1,1));
    vecs.push_back(mk(1,0,0,0,0,0, 1,1,1,1));
    // ack coincident with expiry, then plain ack, then stop, stop in idle
    vecs.push_back(mk(1,0,0,0,0,1, 1,2,1,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,2,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0));
    // stop wins over final tick
    vecs.push_back(mk(0,1,5,0,0,0, 1,5,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,4,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,3,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,2,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(1,0,0,0,1,0, 0,0,0,0));
    // load held while busy, accepted on first idle edge ignoring that tick
    vecs.push_back(mk(0,1,2,0,0,0, 1,2,0,0));
    vecs.push_back(mk(0,1,7,0,0,0, 1,2,0,0));
    vecs.push_back(mk(1,1,7,0,0,0, 1,1,0,0));
    vecs.push_back(mk(1,1,7,0,0,0, 0,0,1,0));
    vecs.push_back(mk(1,1,7,0,0,0, 1,7,1,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,7,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0));
    // zero period expires from idle; second one overruns
    vecs.push_back(mk(0,1,0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(0,1,0,1,0,0, 0,0,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0));
    // maximum period
    vecs.push_back(mk(0,1,65535,0,0,0, 1,65535,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,65534,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0));
    // periodic period 1 expires on every tick
    vecs.push_back(mk(0,1,1,1,0,0, 1,1,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,1,1,1));
    vecs.push_back(mk(0,0,0,0,1,1, 0,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].tick, vecs[i].lv, vecs[i].lp, vecs[i].lper,
            vecs[i].stop, vecs[i].ack);
      @(posedge clk_i);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_rem,
                vecs[i].e_exp, vecs[i].e_ov);
    end

    // asynchronous reset while running with expired set
    drive(0, 1, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    drive(0, 1, 9, 0, 0, 0);
    @(posedge clk_i); #1;
    check_all("pre_rst", 1, 9, 1, 0);
    drive(0, 1, 4, 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    @(posedge clk_i); #1;
    check_all("rst_held", 0, 0, 0, 0);
    #2 rst_ni = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    check_all("post_rst", 0, 0, 0, 0);

    // random stimulus against the model
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit t, lv, lper, s, a;
      int lp;
      t    = ($urandom_range(0, 1) == 1);
      lv   = ($urandom_range(0, 3) == 0);
      lp   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      lper = $urandom_range(0, 1) == 1;
      s    = ($urandom_range(0, 19) == 0);
      a    = ($urandom_range(0, 7) == 0);
      drive(t, lv, lp, lper, s, a);
      @(posedge clk_i);
      model_step(t, lv, lp, lper, s, a);
      #1;
      check_all($sformatf("rnd%0d", n), m_run, m_rem, m_exp, m_ov);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
